// File: rtl/rvh_l1d_snp_ctrl.sv
// Snoop responder for one L1D bank: reads the line's MESI state, fetches dirty data,
// downgrades the line through the LST snoop write port and returns the prior state.
module rvh_l1d_snp_ctrl #(
    parameter int SET_IDX_W = 5,
    parameter int WAY_IDX_W = 2,
    parameter int LINE_W    = 512,
    parameter int ID_W      = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          snp_req_valid,
    output logic                          snp_req_ready,
    input  logic [ID_W-1:0]               snp_req_id,
    input  logic [1:0]                    snp_req_type,
    input  logic                          snp_req_hit,
    input  logic [SET_IDX_W-1:0]          snp_req_set_idx,
    input  logic [WAY_IDX_W-1:0]          snp_req_way_idx,
    output logic [SET_IDX_W-1:0]          lst_rd_idx_snp,
    input  logic [2*(2**WAY_IDX_W)-1:0]   lst_rd_mesi_snp,
    input  logic                          lst_s0_wr_busy,
    output logic                          lst_mesi_wr_en_snp,
    output logic [SET_IDX_W-1:0]          lst_mesi_wr_set_idx_snp,
    output logic [WAY_IDX_W-1:0]          lst_mesi_wr_way_idx_snp,
    output logic [1:0]                    lst_mesi_wr_dat_snp,
    output logic                          data_rd_valid,
    input  logic                          data_rd_ready,
    output logic [SET_IDX_W-1:0]          data_rd_set_idx,
    output logic [WAY_IDX_W-1:0]          data_rd_way_idx,
    input  logic                          data_rd_resp_valid,
    input  logic [LINE_W-1:0]             data_rd_resp_data,
    output logic                          snp_active,
    output logic [SET_IDX_W-1:0]          snp_active_set_idx,
    output logic                          snp_resp_valid,
    input  logic                          snp_resp_ready,
    output logic [ID_W-1:0]               snp_resp_id,
    output logic [1:0]                    snp_resp_prev_state,
    output logic                          snp_resp_dirty,
    output logic [LINE_W-1:0]             snp_resp_data
);

    localparam logic [1:0] MESI_I = 2'd0;
    localparam logic [1:0] MESI_S = 2'd1;
    localparam logic [1:0] MESI_E = 2'd2;
    localparam logic [1:0] MESI_M = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LST_RD,
        S_DATA_REQ,
        S_DATA_WAIT,
        S_LST_WR,
        S_RESP
    } state_e;

    state_e                 r_state;
    logic [ID_W-1:0]        r_id;
    logic [1:0]             r_type;
    logic [SET_IDX_W-1:0]   r_set;
    logic [WAY_IDX_W-1:0]   r_way;
    logic [1:0]             r_prev;
    logic [1:0]             r_next;
    logic                   r_dirty;
    logic [LINE_W-1:0]      r_data;

    logic [1:0]             w_cur_mesi;
    logic [1:0]             w_next_mesi;

    // to-shared only demotes owned lines; query never changes state
    function automatic logic [1:0] f_next_state(input logic [1:0] typ, input logic [1:0] cur);
        logic [1:0] nxt;
        nxt = cur;
        case (typ)
            2'b00:   nxt = ((cur == MESI_M) || (cur == MESI_E)) ? MESI_S : cur;
            2'b01:   nxt = MESI_I;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

    assign w_cur_mesi  = lst_rd_mesi_snp[{r_way, 1'b0} +: 2];
    assign w_next_mesi = f_next_state(r_type, w_cur_mesi);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_id    <= '0;
            r_type  <= '0;
            r_set   <= '0;
            r_way   <= '0;
            r_prev  <= MESI_I;
            r_next  <= MESI_I;
            r_dirty <= 1'b0;
            r_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (snp_req_valid) begin
                        r_id    <= snp_req_id;
                        r_type  <= snp_req_type;
                        r_set   <= snp_req_set_idx;
                        r_way   <= snp_req_way_idx;
                        r_prev  <= MESI_I;
                        r_next  <= MESI_I;
                        r_dirty <= 1'b0;
                        r_data  <= '0;
                        r_state <= snp_req_hit ? S_LST_RD : S_RESP;
                    end
                end
                S_LST_RD: begin
                    r_prev <= w_cur_mesi;
                    r_next <= w_next_mesi;
                    if (w_cur_mesi == MESI_M) begin
                        r_state <= S_DATA_REQ;
                    end else if (w_next_mesi != w_cur_mesi) begin
                        r_state <= S_LST_WR;
                    end else begin
                        r_state <= S_RESP;
                    end
                end
                S_DATA_REQ: begin
                    if (data_rd_ready) begin
                        r_state <= S_DATA_WAIT;
                    end
                end
                // data is captured before any MESI write so a refill cannot race it
                S_DATA_WAIT: begin
                    if (data_rd_resp_valid) begin
                        r_data  <= data_rd_resp_data;
                        r_dirty <= 1'b1;
                        r_state <= (r_next != r_prev) ? S_LST_WR : S_RESP;
                    end
                end
                S_LST_WR: begin
                    if (!lst_s0_wr_busy) begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (snp_resp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign snp_req_ready           = (r_state == S_IDLE);
    assign lst_rd_idx_snp          = r_set;
    assign lst_mesi_wr_en_snp      = (r_state == S_LST_WR) && !lst_s0_wr_busy;
    assign lst_mesi_wr_set_idx_snp = r_set;
    assign lst_mesi_wr_way_idx_snp = r_way;
    assign lst_mesi_wr_dat_snp     = r_next;
    assign data_rd_valid           = (r_state == S_DATA_REQ);
    assign data_rd_set_idx         = r_set;
    assign data_rd_way_idx         = r_way;
    assign snp_active              = (r_state != S_IDLE);
    assign snp_active_set_idx      = r_set;
    assign snp_resp_valid          = (r_state == S_RESP);
    assign snp_resp_id             = r_id;
    assign snp_resp_prev_state     = r_prev;
    assign snp_resp_dirty          = r_dirty;
    assign snp_resp_data           = r_data;

endmodule

// File: tb/tb_rvh_l1d_snp_ctrl.sv
// Directed and randomized snoop sequences against a transaction-level model of the
// snoop responder, with the LST and data array emulated in the bench.
module tb_rvh_l1d_snp_ctrl;

    localparam int SET_IDX_W = 5;
    localparam int WAY_IDX_W = 2;
    localparam int LINE_W    = 512;
    localparam int ID_W      = 4;
    localparam int NWAYS     = 4;
    localparam int NSETS     = 32;

    localparam logic [1:0] I_ST = 2'd0;
    localparam logic [1:0] S_ST = 2'd1;
    localparam logic [1:0] E_ST = 2'd2;
    localparam logic [1:0] M_ST = 2'd3;

    logic                   clk = 1'b0;
    logic                   rstn;
    logic                   snp_req_valid;
    logic                   snp_req_ready;
    logic [ID_W-1:0]        snp_req_id;
    logic [1:0]             snp_req_type;
    logic                   snp_req_hit;
    logic [SET_IDX_W-1:0]   snp_req_set_idx;
    logic [WAY_IDX_W-1:0]   snp_req_way_idx;
    logic [SET_IDX_W-1:0]   lst_rd_idx_snp;
    logic [2*NWAYS-1:0]     lst_rd_mesi_snp;
    logic                   lst_s0_wr_busy;
    logic                   lst_mesi_wr_en_snp;
    logic [SET_IDX_W-1:0]   lst_mesi_wr_set_idx_snp;
    logic [WAY_IDX_W-1:0]   lst_mesi_wr_way_idx_snp;
    logic [1:0]             lst_mesi_wr_dat_snp;
    logic                   data_rd_valid;
    logic                   data_rd_ready;
    logic [SET_IDX_W-1:0]   data_rd_set_idx;
    logic [WAY_IDX_W-1:0]   data_rd_way_idx;
    logic                   data_rd_resp_valid;
    logic [LINE_W-1:0]      data_rd_resp_data;
    logic                   snp_active;
    logic [SET_IDX_W-1:0]   snp_active_set_idx;
    logic                   snp_resp_valid;
    logic                   snp_resp_ready;
    logic [ID_W-1:0]        snp_resp_id;
    logic [1:0]             snp_resp_prev_state;
    logic                   snp_resp_dirty;
    logic [LINE_W-1:0]      snp_resp_data;

    int checks = 0;
    int errors = 0;

    // emulated line state table
    logic [1:0] lst [NSETS][NWAYS];

    always #5 clk = ~clk;

    always_comb begin
        lst_rd_mesi_snp = '0;
        for (int w = 0; w < NWAYS; w++) begin
            lst_rd_mesi_snp[w*2 +: 2] = lst[lst_rd_idx_snp][w];
        end
    end

    rvh_l1d_snp_ctrl #(
        .SET_IDX_W(SET_IDX_W),
        .WAY_IDX_W(WAY_IDX_W),
        .LINE_W(LINE_W),
        .ID_W(ID_W)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .snp_req_valid(snp_req_valid),
        .snp_req_ready(snp_req_ready),
        .snp_req_id(snp_req_id),
        .snp_req_type(snp_req_type),
        .snp_req_hit(snp_req_hit),
        .snp_req_set_idx(snp_req_set_idx),
        .snp_req_way_idx(snp_req_way_idx),
        .lst_rd_idx_snp(lst_rd_idx_snp),
        .lst_rd_mesi_snp(lst_rd_mesi_snp),
        .lst_s0_wr_busy(lst_s0_wr_busy),
        .lst_mesi_wr_en_snp(lst_mesi_wr_en_snp),
        .lst_mesi_wr_set_idx_snp(lst_mesi_wr_set_idx_snp),
        .lst_mesi_wr_way_idx_snp(lst_mesi_wr_way_idx_snp),
        .lst_mesi_wr_dat_snp(lst_mesi_wr_dat_snp),
        .data_rd_valid(data_rd_valid),
        .data_rd_ready(data_rd_ready),
        .data_rd_set_idx(data_rd_set_idx),
        .data_rd_way_idx(data_rd_way_idx),
        .data_rd_resp_valid(data_rd_resp_valid),
        .data_rd_resp_data(data_rd_resp_data),
        .snp_active(snp_active),
        .snp_active_set_idx(snp_active_set_idx),
        .snp_resp_valid(snp_resp_valid),
        .snp_resp_ready(snp_resp_ready),
        .snp_resp_id(snp_resp_id),
        .snp_resp_prev_state(snp_resp_prev_state),
        .snp_resp_dirty(snp_resp_dirty),
        .snp_resp_data(snp_resp_data)
    );

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] model_next(input logic [1:0] typ, input logic [1:0] cur);
        if (typ == 2'b01) return I_ST;
        if (typ == 2'b00 && (cur == E_ST || cur == M_ST)) return S_ST;
        return cur;
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] l;
        for (int k = 0; k < LINE_W / 32; k++) l[k*32 +: 32] = $urandom;
        return l;
    endfunction

    // one complete snoop; called right after a rising edge (+1)
    task automatic run_snoop(input logic [ID_W-1:0] id, input logic [1:0] typ, input logic hit,
                             input logic [SET_IDX_W-1:0] set, input logic [WAY_IDX_W-1:0] way,
                             input int d_rdy, input int lat, input int busy_n, input int bp,
                             input logic [LINE_W-1:0] line);
        logic [1:0]        exp_prev, exp_next;
        logic              exp_wr, exp_m;
        logic [LINE_W-1:0] exp_data;
        int wr_c, resp_c;
        int wr_cnt, wr_cyc, dreq_cnt, dreq_bad, resp_cnt, resp_bad, bad_ready, bad_active;
        int first_resp;
        logic done;
        logic [SET_IDX_W-1:0] wr_set;
        logic [WAY_IDX_W-1:0] wr_way;
        logic [1:0]           wr_dat;

        exp_prev = hit ? lst[set][way] : I_ST;
        exp_next = hit ? model_next(typ, exp_prev) : I_ST;
        exp_wr   = hit && (exp_next != exp_prev);
        exp_m    = hit && (exp_prev == M_ST);
        exp_data = exp_m ? line : '0;
        wr_c     = exp_m ? 3 + d_rdy + lat : 2;
        if (!hit)        resp_c = 1;
        else if (exp_wr) resp_c = wr_c + busy_n + 1;
        else             resp_c = exp_m ? 3 + d_rdy + lat : 2;

        wr_cnt = 0; wr_cyc = -1; dreq_cnt = 0; dreq_bad = 0; resp_cnt = 0; resp_bad = 0;
        bad_ready = 0; bad_active = 0; first_resp = -1; done = 1'b0;
        wr_set = '0; wr_way = '0; wr_dat = '0;

        snp_req_valid = 1'b1; snp_req_id = id; snp_req_type = typ; snp_req_hit = hit;
        snp_req_set_idx = set; snp_req_way_idx = way;
        data_rd_ready = 1'b0; data_rd_resp_valid = 1'b0; lst_s0_wr_busy = 1'b0; snp_resp_ready = 1'b0;
        #1;
        chk("req_ready_idle", snp_req_ready, 1'b1);
        @(posedge clk); #1;
        snp_req_valid = 1'b0;

        for (int cyc = 1; cyc <= 100; cyc++) begin
            data_rd_ready      = (cyc >= 2 + d_rdy);
            data_rd_resp_valid = exp_m && (cyc == 2 + d_rdy + lat);
            data_rd_resp_data  = data_rd_resp_valid ? line : rand_line();
            lst_s0_wr_busy     = (cyc >= wr_c) && (cyc < wr_c + busy_n);
            snp_resp_ready     = (cyc >= resp_c + bp);
            #1;
            if (snp_req_ready) bad_ready++;
            if (!snp_active || snp_active_set_idx != set) bad_active++;
            if (lst_mesi_wr_en_snp) begin
                wr_cnt++;
                if (wr_cyc < 0) begin
                    wr_cyc = cyc; wr_set = lst_mesi_wr_set_idx_snp;
                    wr_way = lst_mesi_wr_way_idx_snp; wr_dat = lst_mesi_wr_dat_snp;
                end
                lst[lst_mesi_wr_set_idx_snp][lst_mesi_wr_way_idx_snp] = lst_mesi_wr_dat_snp;
            end
            if (data_rd_valid) begin
                dreq_cnt++;
                if (data_rd_set_idx != set || data_rd_way_idx != way) dreq_bad++;
            end
            if (snp_resp_valid) begin
                resp_cnt++;
                if (first_resp < 0) first_resp = cyc;
                if (snp_resp_id != id || snp_resp_prev_state != exp_prev ||
                    snp_resp_dirty != exp_m || snp_resp_data != exp_data) resp_bad++;
                if (first_resp == cyc) begin
                    chk("resp_id", snp_resp_id, id);
                    chk("resp_prev", snp_resp_prev_state, exp_prev);
                    chk("resp_dirty", snp_resp_dirty, exp_m);
                    chk("resp_data", snp_resp_data, exp_data);
                end
                if (snp_resp_ready) done = 1'b1;
            end
            @(posedge clk); #1;
            if (done) break;
        end
        snp_resp_ready = 1'b0; lst_s0_wr_busy = 1'b0; data_rd_resp_valid = 1'b0; data_rd_ready = 1'b0;

        chk("resp_done", done, 1'b1);
        chk("resp_cycle", first_resp, resp_c);
        chk("resp_hold_cycles", resp_cnt, bp + 1);
        chk("resp_stable", resp_bad, 0);
        chk("wr_count", wr_cnt, exp_wr ? 1 : 0);
        if (exp_wr) begin
            chk("wr_cycle", wr_cyc, wr_c + busy_n);
            chk("wr_set", wr_set, set);
            chk("wr_way", wr_way, way);
            chk("wr_dat", wr_dat, exp_next);
        end
        chk("dreq_cycles", dreq_cnt, exp_m ? d_rdy + 1 : 0);
        chk("dreq_addr", dreq_bad, 0);
        chk("req_ready_busy", bad_ready, 0);
        chk("active_busy", bad_active, 0);
        chk("active_after", snp_active, 1'b0);
        chk("resp_valid_after", snp_resp_valid, 1'b0);
    endtask

    initial begin
        int rst_wr, rst_resp;
        rstn = 1'b0;
        snp_req_valid = 1'b0; snp_req_id = '0; snp_req_type = '0; snp_req_hit = 1'b0;
        snp_req_set_idx = '0; snp_req_way_idx = '0; lst_s0_wr_busy = 1'b0;
        data_rd_ready = 1'b0; data_rd_resp_valid = 1'b0; data_rd_resp_data = '0; snp_resp_ready = 1'b0;
        for (int s = 0; s < NSETS; s++)
            for (int w = 0; w < NWAYS; w++) lst[s][w] = 2'($urandom_range(0, 3));

        repeat (3) @(posedge clk);
        #1;
        chk("rst_active", snp_active, 1'b0);
        chk("rst_resp_valid", snp_resp_valid, 1'b0);
        chk("rst_data_rd_valid", data_rd_valid, 1'b0);
        chk("rst_wr_en", lst_mesi_wr_en_snp, 1'b0);
        chk("rst_resp_id", snp_resp_id, '0);
        chk("rst_resp_data", snp_resp_data, '0);
        chk("rst_req_ready", snp_req_ready, 1'b1);
        rstn = 1'b1;
        @(posedge clk); #1;

        // miss
        run_snoop(4'd3, 2'b01, 1'b0, 5'd7, 2'd1, 0, 1, 0, 0, '0);
        // E line to-shared
        lst[5][2] = E_ST;
        run_snoop(4'd9, 2'b00, 1'b1, 5'd5, 2'd2, 0, 1, 0, 0, '0);
        // M line to-invalid, delayed data accept
        lst[12][3] = M_ST;
        run_snoop(4'd1, 2'b01, 1'b1, 5'd12, 2'd3, 2, 2, 0, 0, {64{8'hA5}});
        // S line query, M line query
        lst[20][0] = S_ST;
        run_snoop(4'd4, 2'b10, 1'b1, 5'd20, 2'd0, 0, 1, 0, 0, '0);
        lst[21][1] = M_ST;
        run_snoop(4'd5, 2'b11, 1'b1, 5'd21, 2'd1, 1, 1, 0, 0, rand_line());
        // E line to-invalid against a busy request pipeline
        lst[3][1] = E_ST;
        run_snoop(4'd6, 2'b01, 1'b1, 5'd3, 2'd1, 0, 1, 3, 0, '0);
        // response backpressure
        lst[8][2] = E_ST;
        run_snoop(4'd10, 2'b00, 1'b1, 5'd8, 2'd2, 0, 1, 0, 4, '0);

        // reset during DATA_WAIT
        lst[9][1] = M_ST;
        snp_req_valid = 1'b1; snp_req_id = 4'd7; snp_req_type = 2'b01; snp_req_hit = 1'b1;
        snp_req_set_idx = 5'd9; snp_req_way_idx = 2'd1;
        @(posedge clk); #1;
        snp_req_valid = 1'b0; data_rd_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        data_rd_ready = 1'b0;
        chk("pre_rst_active", snp_active, 1'b1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_active", snp_active, 1'b0);
        chk("mid_rst_active_set", snp_active_set_idx, '0);
        chk("mid_rst_data_rd_valid", data_rd_valid, 1'b0);
        chk("mid_rst_wr_en", lst_mesi_wr_en_snp, 1'b0);
        chk("mid_rst_resp_valid", snp_resp_valid, 1'b0);
        chk("mid_rst_resp_prev", snp_resp_prev_state, '0);
        chk("mid_rst_lst_rd_idx", lst_rd_idx_snp, '0);
        @(posedge clk); #1;
        rstn = 1'b1;
        rst_wr = 0; rst_resp = 0;
        data_rd_resp_valid = 1'b1; data_rd_resp_data = rand_line();
        for (int c = 0; c < 3; c++) begin
            #1;
            if (lst_mesi_wr_en_snp) rst_wr++;
            if (snp_resp_valid) rst_resp++;
            @(posedge clk); #1;
        end
        data_rd_resp_valid = 1'b0;
        chk("post_rst_no_write", rst_wr, 0);
        chk("post_rst_no_resp", rst_resp, 0);
        chk("post_rst_lst_kept", lst[9][1], M_ST);
        run_snoop(4'd7, 2'b01, 1'b1, 5'd9, 2'd1, 0, 1, 0, 0, rand_line());

        // randomized snoops
        for (int n = 0; n < 40; n++) begin
            logic [SET_IDX_W-1:0] rs;
            logic [WAY_IDX_W-1:0] rw;
            rs = 5'($urandom); rw = 2'($urandom);
            if ($urandom_range(0, 1) == 1) lst[rs][rw] = 2'($urandom);
            run_snoop(4'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0), rs, rw,
                      $urandom_range(0, 2), $urandom_range(1, 3), $urandom_range(0, 2),
                      $urandom_range(0, 2), rand_line());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rvh_l1d_snp_ctrl.md
Name: rvh_l1d_snp_ctrl

Overview:
- Snoop responder for one L1D bank; the coherence-side counterpart of the bank's line state table (LST).
- Accepts one snoop at a time from the interconnect, already resolved to a set/way hit or miss, and reads the line's MESI state from the LST.
- For MODIFIED lines, fetches the line from the data array before downgrading.
- Writes the new state through the LST snoop write port and returns a response carrying the prior state and, if dirty, the line data.

Parameters:
SET_IDX_W, 5, set index width (= L1D_BANK_SET_INDEX_WIDTH)
WAY_IDX_W, 2, way index width (= L1D_BANK_WAY_INDEX_WIDTH)
LINE_W, 512, cache line data width in bits
ID_W, 4, snoop transaction id width

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
snp_req_valid  in  1  snoop request valid
snp_req_ready  out  1  snoop request accept
snp_req_id  in  ID_W  transaction id, echoed in response
snp_req_type  in  2  00 to-shared, 01 to-invalid, 10/11 query (no state change)
snp_req_hit  in  1  line present in bank
snp_req_set_idx  in  SET_IDX_W  target set
snp_req_way_idx  in  WAY_IDX_W  target way (ignored on miss)
lst_rd_idx_snp  out  SET_IDX_W  LST read set index
lst_rd_mesi_snp  in  2*2^WAY_IDX_W  combinational LST read data, per-way MESI (way0 in LSBs)
lst_s0_wr_busy  in  1  request pipeline writes LST MESI this cycle
lst_mesi_wr_en_snp  out  1  LST snoop write enable
lst_mesi_wr_set_idx_snp  out  SET_IDX_W  write set
lst_mesi_wr_way_idx_snp  out  WAY_IDX_W  write way
lst_mesi_wr_dat_snp  out  2  new state (rrv64_mesi_type_e)
data_rd_valid  out  1  data array read request
data_rd_ready  in  1  data array accept
data_rd_set_idx  out  SET_IDX_W  read set
data_rd_way_idx  out  WAY_IDX_W  read way
data_rd_resp_valid  in  1  read data return
data_rd_resp_data  in  LINE_W  line data
snp_active  out  1  snoop in flight (pipeline stalls same-set s0 MESI ops)
snp_active_set_idx  out  SET_IDX_W  set of the in-flight snoop
snp_resp_valid  out  1  response valid
snp_resp_ready  in  1  response accept
snp_resp_id  out  ID_W  echoed id
snp_resp_prev_state  out  2  MESI state before the snoop
snp_resp_dirty  out  1  snp_resp_data valid (prior state MODIFIED)
snp_resp_data  out  LINE_W  line data

Behaviour:
- MESI encoding: INVALID=0, SHARED=1, EXCLUSIVE=2, MODIFIED=3.
- Reset:
  - FSM goes to IDLE.
  - All valid/enable outputs are 0; snp_active is 0.
  - All registered id/index/state/data fields are 0.
- FSM: IDLE, LST_RD, DATA_REQ, DATA_WAIT, LST_WR, RESP. One snoop in flight; no pipelining.
- IDLE:
  - snp_req_ready=1 (only state asserting it).
  - On valid&ready, register id/type/hit/set/way.
  - hit=1 -> LST_RD. hit=0 -> RESP with prev_state=INVALID, dirty=0, no LST access.
- LST_RD:
  - lst_rd_idx_snp=registered set.
  - Capture the way's MESI into prev_state.
  - Compute next state:
    - to-shared: M/E -> S; S, I unchanged.
    - to-invalid: any -> I.
    - query: unchanged.
  - Transition: prev==M -> DATA_REQ; else next!=prev -> LST_WR; else -> RESP.
- DATA_REQ: data_rd_valid=1 with set/way held until data_rd_ready; then -> DATA_WAIT.
- DATA_WAIT: on data_rd_resp_valid capture data and set dirty=1; then -> LST_WR if next!=prev, else RESP. A query on an M line reads data but writes no state.
- LST_WR:
  - lst_mesi_wr_en_snp=1 only when lst_s0_wr_busy=0; set/way/dat driven from registers.
  - Stall in LST_WR while busy; exactly one write pulse per snoop.
  - Then -> RESP.
  - Data is read before the MESI write, so a refill into the freed way cannot corrupt returned data.
- RESP: snp_resp_valid=1, fields stable until snp_resp_ready; on handshake -> IDLE. The next request is accepted no earlier than the following cycle.
- snp_active=1 in every state except IDLE; snp_active_set_idx holds the registered set.
- Latency from accept cycle (c0), ready tied high:
  - Miss: resp at c1.
  - Hit, no change: resp at c2.
  - Hit with write: write at c2, resp at c3.
  - M hit: DATA_REQ c2, plus the data array latency, then LST_WR, then RESP.
- snp_resp_data is zero when dirty=0; it is cleared on each accept.
- Reset mid-operation returns the FSM to IDLE with no further LST write; the interconnect reissues the snoop.

Test Plan:
- Miss: hit=0, id=3 -> resp at c1: id=3, prev=I, dirty=0; no LST read/write, no data request.
- E line, to-shared, set=5 way=2 -> write en at c2 (set 5, way 2, dat=S); resp at c3: prev=E, dirty=0.
- M line, to-invalid, data_rd_ready delayed 2 cycles, data=0xA5 pattern -> single data request held stable; write dat=I after data capture; resp prev=M, dirty=1, data=0xA5 pattern.
- S line, query type 2'b10 -> no write; resp at c2: prev=S. Also: M line, query -> data returned, no write.
- E line, to-invalid, lst_s0_wr_busy high for 3 cycles in LST_WR -> wr_en low while busy, then exactly one pulse; snp_active high throughout.
- Response backpressure: snp_resp_ready low 4 cycles -> fields stable, snp_req_ready=0. Assert rstn low mid DATA_WAIT -> all outputs 0; next snoop completes normally.
